keypad: RTL and testbench
=========================

# keypad

Debounced key input block for the Pokémon Mini system bus. It synchronises and debounces the eight raw button lines and exposes key state and edge-select registers on the CPU register bus. It also emits one-cycle interrupt pulses into the `irq` controller's `irqs` vector at sources 0x15–0x1C. It sits beside `timer`/`timer256` in `minx`, and its `bus_data_out` is OR-ed into `reg_data_out`.

## Interface
- `DEBOUNCE_CYCLES`, default 4096: consecutive clocks a synchronised key level must differ from the stable state before it is accepted; legal range 1..65535.
- `clk` in 1: system clock; all state updates on rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low. All flops clear on `reset`==0.
- `keys` in 8: raw button levels, 1 = pressed, asynchronous to `clk`. Bit order: 0 A, 1 B, 2 C, 3 up, 4 down, 5 left, 6 right, 7 power.
- `bus_write` in 1: CPU register write strobe.
- `bus_read` in 1: CPU register read strobe.
- `bus_address_in` in 24: register bus address.
- `bus_data_in` in 8: write data.
- `bus_data_out` in/out: out 8: read data; 0x00 whenever not selected, so it can be OR-ed.
- `irqs` out 8: per-key one-cycle interrupt pulse; bit n maps to irq source 0x15+n.

## Operation
- Register 0x2050, KEY_EDGE, R/W, reset 0x00. Bit n = 0 fires irq n on press; bit n = 1 fires on release.
- Register 0x2052, KEY_STATE, read-only, active-low. Reads ~stable[7:0], so 0xFF means no key pressed. Writes are ignored.
- Write: on a rising edge with `bus_write`=1 and `bus_address_in`==0x2050, KEY_EDGE <= `bus_data_in`.
- Read: `bus_data_out` is combinational. It equals KEY_EDGE when `bus_read`=1 and the address is 0x2050. It equals ~stable when `bus_read`=1 and the address is 0x2052. Otherwise it is 0x00.
- Per key: two-flop synchroniser sync1→sync2, then a debounce counter, 16 bits saturating at DEBOUNCE_CYCLES, then the stable bit.
  - sync2 == stable: counter <= 0.
  - sync2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync2 and counter <= 0.
  - Otherwise: counter <= counter+1.
- Any bounce, i.e. sync2 returning to stable before acceptance, restarts the count from 0.
- irq n <= 1 in the same clock edge that stable n flips, if the new level matches the edge select: new stable = 1 with KEY_EDGE[n] = 0, or new stable = 0 with KEY_EDGE[n] = 1. In all other cycles irq n <= 0.
- Simultaneous acceptance on several keys asserts several `irqs` bits in the same cycle.
- A KEY_EDGE write in the same edge as a stable flip: the flip uses the old KEY_EDGE value.
- Reset values: sync1, sync2, stable, counters and `irqs` are all 0; KEY_EDGE = 0x00; `bus_data_out` = 0x00 (KEY_STATE reads 0xFF).
- Reset asserted mid-debounce discards the count. After release, a key held down is re-accepted after the full latency below.

## Timing
- `keys` change sampled at edge k:
  - sync1 updates at k; sync2 at k+1.
  - stable and `irqs` update at k+DEBOUNCE_CYCLES+1.
  - `irqs` pulse stays high for exactly one cycle.
- KEY_STATE reflects the new value from cycle k+DEBOUNCE_CYCLES+1 onward.
- Register write takes effect on the next edge; a read-after-write in the following cycle returns the new value.
- No wait states; reads complete in the cycle `bus_read` is high.

## Structure
- Shared package `minx_pkg` holds:
  - register address constants: KEYPAD_REG_EDGE = 24'h2050, KEYPAD_REG_STATE = 24'h2052;
  - key index enum KEY_A..KEY_POWER;
  - IRQ_KEY_BASE = 5'h15.
- Sub-module `key_debounce` (per key: synchroniser, counter, stable bit, edge outputs `rise` and `fall`), instantiated 8× by generate.
- `keypad` top holds KEY_EDGE, the irq select logic and bus decode.
- `minx` maps `irqs[n]` to `irqs[5'h15+n]`.

## Test plan
- Reset: hold `reset`=0 with `keys`=0x05 → `irqs`=0, read 0x2052 = 0xFF. Release, keep `keys`=0x05 → after DEBOUNCE_CYCLES+2 clocks, read 0x2052 = 0xFA and `irqs`=0x05 for one cycle.
- Clean press, DEBOUNCE_CYCLES=8, KEY_EDGE=0: `keys[0]` 0→1 at edge k → `irqs[0]`=1 only in the cycle after edge k+9; KEY_STATE bit0 = 0 from then on.
- Bounce: toggle `keys[3]` every 5 clocks, D=8 → no `irqs`, KEY_STATE stays 0xFF. Then hold it 1 → accepted 9 clocks after the last transition.
- Release edge: write 0x2050 = 0x80; press and release `keys[7]` → no irq on press, `irqs[7]` pulse on release. Read 0x2050 = 0x80 and write 0x2052 = 0x00 ignored.
- Simultaneous: `keys` 0x00→0x60 in one cycle → `irqs`=0x60 in a single cycle.
- Bus isolation: `bus_read`=1 at 0x2051, 0x2053 and 0x2060 → `bus_data_out`=0x00. Reset pulse mid-count, then re-press → full latency restarts.

Source files
------------

// File: rtl/minx_pkg.sv
// Shared Pokemon Mini constants: register map, key indices and irq numbering
// for the keypad block.
package minx_pkg;

    localparam logic [23:0] KEYPAD_REG_EDGE  = 24'h2050;
    localparam logic [23:0] KEYPAD_REG_STATE = 24'h2052;

    localparam logic [4:0] IRQ_KEY_BASE = 5'h15;

    typedef enum logic [2:0] {
        KEY_A     = 3'd0,
        KEY_B     = 3'd1,
        KEY_C     = 3'd2,
        KEY_UP    = 3'd3,
        KEY_DOWN  = 3'd4,
        KEY_LEFT  = 3'd5,
        KEY_RIGHT = 3'd6,
        KEY_POWER = 3'd7
    } key_index_t;

endpackage

// File: rtl/key_debounce.sv
// One button: two-flop synchroniser, consecutive-mismatch counter and the
// accepted stable level, with single-cycle accept strobes for each direction.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 4096
) (
    input  logic clk,
    input  logic reset,
    input  logic key_raw,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam logic [15:0] LAST_COUNT = 16'(DEBOUNCE_CYCLES - 1);

    logic        sync1;
    logic        sync2;
    logic [15:0] count;
    logic        accept;

    // rise/fall describe the flip that the coming edge will perform, so the
    // parent can register its irq on the same edge that stable changes.
    assign accept = (sync2 != stable) && (count == LAST_COUNT);
    assign rise   = accept & sync2;
    assign fall   = accept & ~sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            count  <= 16'd0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
            if (sync2 == stable) begin
                count <= 16'd0;
            end else if (accept) begin
                stable <= sync2;
                count  <= 16'd0;
            end else begin
                count <= count + 16'd1;
            end
        end
    end

endmodule

// File: rtl/keypad.sv
// Debounced keypad: eight key_debounce lanes, the KEY_EDGE select register,
// per-key irq pulses and the OR-able CPU register read port.
module keypad
    import minx_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  keys,
    input  logic        bus_write,
    input  logic        bus_read,
    input  logic [23:0] bus_address_in,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    output logic [7:0]  irqs
);

    logic [7:0] stable;
    logic [7:0] rise;
    logic [7:0] fall;
    logic [7:0] key_edge;

    for (genvar n = 0; n < 8; n++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .key_raw(keys[n]),
            .stable (stable[n]),
            .rise   (rise[n]),
            .fall   (fall[n])
        );
    end

    // The irq term reads key_edge before this edge's write lands, so a flip
    // coinciding with a KEY_EDGE write honours the old select.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_edge <= 8'h00;
            irqs     <= 8'h00;
        end else begin
            irqs <= (rise & ~key_edge) | (fall & key_edge);
            if (bus_write && bus_address_in == KEYPAD_REG_EDGE) begin
                key_edge <= bus_data_in;
            end
        end
    end

    always_comb begin
        bus_data_out = 8'h00;
        if (bus_read) begin
            if (bus_address_in == KEYPAD_REG_EDGE) begin
                bus_data_out = key_edge;
            end else if (bus_address_in == KEYPAD_REG_STATE) begin
                bus_data_out = ~stable;
            end
        end
    end

endmodule

// File: tb/tb_keypad.sv
// Directed and randomised checks of keypad against a sample-window model of
// the debounce rule, with DEBOUNCE_CYCLES reduced to 8.
module tb_keypad;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  keys;
    logic        bus_write;
    logic        bus_read;
    logic [23:0] bus_address_in;
    logic [7:0]  bus_data_in;
    logic [7:0]  bus_data_out;
    logic [7:0]  irqs;

    int total = 0;
    int bad   = 0;

    // Model: keys as captured at each edge, accepted level, select and irqs.
    logic [7:0] hist[$];
    logic [7:0] m_stable;
    logic [7:0] m_edge;
    logic [7:0] m_irqs;

    keypad #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .keys          (keys),
        .bus_write     (bus_write),
        .bus_read      (bus_read),
        .bus_address_in(bus_address_in),
        .bus_data_in   (bus_data_in),
        .bus_data_out  (bus_data_out),
        .irqs          (irqs)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        hist.delete();
        for (int i = 0; i < D + 2; i++) hist.push_back(8'h00);
        m_stable = 8'h00;
        m_edge   = 8'h00;
        m_irqs   = 8'h00;
    endtask

    // One clock: a key is accepted once the level it was sampled at two edges
    // earlier has disagreed with the accepted level for D samples in a row.
    task automatic applyStimulus();
        logic [7:0] flip;
        logic [7:0] new_stable;
        logic [7:0] sample;
        logic [7:0] exp_rd;
        logic       all_diff;
        @(posedge clk);
        hist.push_back(keys);
        sample = hist.pop_front();
        flip = 8'h00;
        for (int b = 0; b < 8; b++) begin
            all_diff = 1'b1;
            for (int i = 0; i < D; i++) begin
                sample = hist[i];
                if (sample[b] == m_stable[b]) all_diff = 1'b0;
            end
            flip[b] = all_diff;
        end
        new_stable = m_stable ^ flip;
        m_irqs     = flip & (new_stable ^ m_edge);
        m_stable   = new_stable;
        if (bus_write && bus_address_in == 24'h2050) m_edge = bus_data_in;
        #1;
        exp_rd = 8'h00;
        if (bus_read && bus_address_in == 24'h2050) exp_rd = m_edge;
        if (bus_read && bus_address_in == 24'h2052) exp_rd = ~m_stable;
        checkOutput("irqs", irqs, m_irqs);
        checkOutput("bus_read", bus_data_out, exp_rd);
    endtask

    task automatic settle();
        repeat (2 * D + 4) applyStimulus();
    endtask

    initial begin
        reset          = 1'b0;
        keys           = 8'h05;
        bus_write      = 1'b0;
        bus_read       = 1'b1;
        bus_address_in = 24'h2052;
        bus_data_in    = 8'h00;

        // Held in reset with keys down: nothing leaks through.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_irqs", irqs, 8'h00);
        checkOutput("reset_state", bus_data_out, 8'hFF);
        reset = 1'b1;
        modelReset();
        repeat (D + 1) applyStimulus();
        applyStimulus();
        checkOutput("reset_accept_irq", irqs, 8'h05);
        checkOutput("reset_accept_state", bus_data_out, 8'hFA);
        applyStimulus();
        checkOutput("reset_irq_one_cycle", irqs, 8'h00);

        // Clean press of A.
        keys = 8'h00;
        settle();
        keys = 8'h01;
        repeat (D + 1) applyStimulus();
        applyStimulus();
        checkOutput("press_irq", irqs, 8'h01);
        checkOutput("press_state", bus_data_out, 8'hFE);
        applyStimulus();
        checkOutput("press_irq_drop", irqs, 8'h00);

        // Bounce on UP faster than the debounce window, then a steady hold.
        for (int t = 0; t < 6; t++) begin
            keys[3] = ~keys[3];
            repeat (5) applyStimulus();
        end
        checkOutput("bounce_state", bus_data_out, 8'hFE);
        keys[3] = 1'b1;
        repeat (D + 1) applyStimulus();
        applyStimulus();
        checkOutput("bounce_accept_irq", irqs, 8'h08);

        // Release-edge select on POWER; KEY_STATE writes are ignored.
        keys = 8'h00;
        settle();
        bus_write = 1'b1; bus_address_in = 24'h2050; bus_data_in = 8'h80;
        applyStimulus();
        bus_write = 1'b0;
        applyStimulus();
        checkOutput("edge_readback", bus_data_out, 8'h80);
        bus_write = 1'b1; bus_address_in = 24'h2052; bus_data_in = 8'h00;
        applyStimulus();
        bus_write = 1'b0; bus_address_in = 24'h2050;
        applyStimulus();
        checkOutput("edge_after_state_write", bus_data_out, 8'h80);
        bus_address_in = 24'h2052;
        keys = 8'h80;
        repeat (D + 4) applyStimulus();
        checkOutput("power_pressed_state", bus_data_out, 8'h7F);
        keys = 8'h00;
        repeat (D + 1) applyStimulus();
        applyStimulus();
        checkOutput("release_irq", irqs, 8'h80);

        // Two keys accepted together.
        bus_write = 1'b1; bus_address_in = 24'h2050; bus_data_in = 8'h00;
        applyStimulus();
        bus_write = 1'b0; bus_address_in = 24'h2052;
        settle();
        keys = 8'h60;
        repeat (D + 1) applyStimulus();
        applyStimulus();
        checkOutput("simultaneous_irq", irqs, 8'h60);

        // Unmapped addresses read as zero.
        bus_address_in = 24'h2051; applyStimulus();
        checkOutput("iso_2051", bus_data_out, 8'h00);
        bus_address_in = 24'h2053; applyStimulus();
        checkOutput("iso_2053", bus_data_out, 8'h00);
        bus_address_in = 24'h2060; applyStimulus();
        checkOutput("iso_2060", bus_data_out, 8'h00);
        bus_address_in = 24'h2052;

        // Reset in the middle of a count restarts the full latency.
        keys = 8'h00;
        settle();
        keys = 8'h02;
        repeat (D / 2) applyStimulus();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("midreset_state", bus_data_out, 8'hFF);
        reset = 1'b1;
        modelReset();
        repeat (D + 1) applyStimulus();
        applyStimulus();
        checkOutput("midreset_reaccept", irqs, 8'h02);

        // Random key activity, edge-select writes and bus reads.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 9) == 0) keys[$urandom_range(0, 7)] ^= 1'b1;
            bus_write = 1'b0;
            bus_read  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       bus_address_in = 24'h2050;
                1:       bus_address_in = 24'h2051;
                default: bus_address_in = 24'h2052;
            endcase
            if ($urandom_range(0, 39) == 0) begin
                bus_write      = 1'b1;
                bus_address_in = ($urandom_range(0, 1) == 0) ? 24'h2050 : 24'h2052;
                bus_data_in    = 8'($urandom);
            end
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
